// File: rtl/mips_mem_pkg.sv
// Shared encodings and defaults for the MIPS data-memory stage.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  localparam int DMEM_ADDR_WIDTH = 8;
  localparam int WORD_W          = 32;
  localparam int LANES           = WORD_W / 8;

  typedef struct packed {
    logic [WORD_W-1:0] ldata;
    logic [LANES-1:0]  wmask;
    logic [WORD_W-1:0] wword;
    logic              misaligned;
  } align_rsp_t;

  function automatic logic [WORD_W-1:0] extend(input logic [15:0] v, input logic is_half,
                                               input logic zext);
    logic sgn;
    sgn = is_half ? v[15] : v[7];
    if (is_half) return {{16{sgn & ~zext}}, v};
    return {{24{sgn & ~zext}}, v[7:0]};
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Lane steering between the byte address and the word-wide RAM: load extraction,
// store replication, byte write mask and alignment check.
module dmem_lane_align
  import mips_mem_pkg::*;
(
  input  logic [1:0]        off,
  input  size_e             size,
  input  logic              unsigned_load,
  input  logic [WORD_W-1:0] rword,
  input  logic [WORD_W-1:0] wdata,
  output align_rsp_t        rsp
);

  logic [WORD_W-1:0] shifted;

  // Bring the addressed byte/half down to bit 0 before extending.
  assign shifted = rword >> {off, 3'b000};

  always_comb begin
    rsp = '0;
    unique case (size)
      SIZE_BYTE: begin
        rsp.wmask = 4'b0001 << off;
        rsp.wword = {4{wdata[7:0]}};
        rsp.ldata = extend(shifted[15:0], 1'b0, unsigned_load);
      end
      SIZE_HALF: begin
        rsp.misaligned = off[0];
        rsp.wmask      = off[1] ? 4'b1100 : 4'b0011;
        rsp.wword      = {2{wdata[15:0]}};
        rsp.ldata      = extend(shifted[15:0], 1'b1, unsigned_load);
      end
      SIZE_WORD: begin
        rsp.misaligned = (off != 2'b00);
        rsp.wmask      = 4'b1111;
        rsp.wword      = wdata;
        rsp.ldata      = rword;
      end
      default: rsp.misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_load_store.sv
// Data memory stage: word-organised RAM with combinational loads, masked
// synchronous stores, and a sticky misalignment fault register.
module dmem_load_store
  import mips_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        unsigned_load,
  output logic [31:0] rdata,
  output logic        misaligned,
  output logic        fault,
  output logic [31:0] fault_addr,
  input  logic        fault_clear
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [WORD_W-1:0]     mem [DEPTH];
  logic [ADDR_WIDTH-1:0] widx;
  logic [WORD_W-1:0]     rword;
  logic                  access;
  logic                  do_write;
  align_rsp_t            rsp;

  assign widx     = addr[ADDR_WIDTH+1:2];
  assign rword    = mem[widx];
  assign access   = mem_read | mem_write;

  dmem_lane_align u_align (
    .off          (addr[1:0]),
    .size         (size_e'(size)),
    .unsigned_load(unsigned_load),
    .rword        (rword),
    .wdata        (wdata),
    .rsp          (rsp)
  );

  assign misaligned = access & rsp.misaligned;
  assign rdata      = (mem_read && !misaligned) ? rsp.ldata : '0;
  assign do_write   = rst_n & mem_write & ~misaligned;

  // RAM is deliberately not reset; reset only gates the write enable.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int k = 0; k < LANES; k++)
        if (rsp.wmask[k]) mem[widx][8*k +: 8] <= rsp.wword[8*k +: 8];
    end
  end

  // A new fault takes priority over a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault      <= 1'b0;
      fault_addr <= '0;
    end else if (misaligned) begin
      fault <= 1'b1;
      if (!fault || fault_clear) fault_addr <= addr;
    end else if (fault_clear) begin
      fault      <= 1'b0;
      fault_addr <= '0;
    end
  end

endmodule

// File: tb/tb_dmem_load_store.sv
// Directed checks of loads, stores, alignment faults, reset and address wrap.
module tb_dmem_load_store;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr, wdata, rdata, fault_addr;
  logic        mem_read, mem_write, unsigned_load, misaligned, fault, fault_clear;
  logic [1:0]  size;
  int          n_chk = 0, n_pass = 0;

  dmem_load_store #(.ADDR_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .mem_read(mem_read),
    .mem_write(mem_write), .size(size), .unsigned_load(unsigned_load), .rdata(rdata),
    .misaligned(misaligned), .fault(fault), .fault_addr(fault_addr), .fault_clear(fault_clear)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic idle();
    mem_read = 0; mem_write = 0; fault_clear = 0; unsigned_load = 0; size = 2'b10;
  endtask

  task automatic edge1();
    @(posedge clk); #1;
  endtask

  task automatic drv(input logic r, input logic w, input logic [1:0] sz, input logic u,
                     input logic [31:0] a, input logic [31:0] d);
    mem_read = r; mem_write = w; size = sz; unsigned_load = u; addr = a; wdata = d;
    #1;
  endtask

  task automatic store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    drv(0, 1, sz, 0, a, d);
    edge1();
    idle();
  endtask

  initial begin
    idle(); addr = 0; wdata = 0; rst_n = 0;
    #1;
    chk("rst_fault", {31'b0, fault}, 32'd0);
    chk("rst_faddr", fault_addr, 32'd0);
    @(negedge clk); @(negedge clk); rst_n = 1;
    edge1();

    store(2'b10, 32'h14, 32'h01234567);
    store(2'b10, 32'h10, 32'hDEADBEEF);
    drv(1, 0, 2'b10, 0, 32'h10, 0); chk("lw_10", rdata, 32'hDEADBEEF);
    chk("lw_10_mis", {31'b0, misaligned}, 32'd0);
    drv(1, 0, 2'b10, 1, 32'h10, 0); chk("lw_10_u", rdata, 32'hDEADBEEF);
    drv(1, 0, 2'b10, 0, 32'h14, 0); chk("lw_14", rdata, 32'h01234567);
    drv(1, 0, 2'b00, 0, 32'h13, 0); chk("lb_13", rdata, 32'hFFFFFFDE);
    drv(1, 0, 2'b00, 1, 32'h13, 0); chk("lbu_13", rdata, 32'h000000DE);
    drv(1, 0, 2'b00, 0, 32'h10, 0); chk("lb_10", rdata, 32'hFFFFFFEF);
    drv(1, 0, 2'b00, 1, 32'h11, 0); chk("lbu_11", rdata, 32'h000000BE);
    drv(1, 0, 2'b01, 0, 32'h10, 0); chk("lh_10", rdata, 32'hFFFFBEEF);
    drv(1, 0, 2'b01, 1, 32'h12, 0); chk("lhu_12", rdata, 32'h0000DEAD);
    drv(1, 0, 2'b01, 0, 32'h12, 0); chk("lh_12", rdata, 32'hFFFFDEAD);
    drv(0, 0, 2'b10, 0, 32'h10, 0); chk("noread_0", rdata, 32'd0);
    idle();

    store(2'b00, 32'h11, 32'hFFFFFF55);
    store(2'b01, 32'h12, 32'hABCD1234);
    drv(1, 0, 2'b10, 0, 32'h10, 0); chk("partial_10", rdata, 32'h123455EF);
    drv(1, 0, 2'b10, 0, 32'h14, 0); chk("partial_14", rdata, 32'h01234567);
    drv(1, 0, 2'b01, 1, 32'h12, 0); chk("lhu_1234", rdata, 32'h00001234);
    idle();

    // Misaligned store is suppressed and latched as the first fault.
    store(2'b10, 32'h20, 32'hAAAAAAAA);
    drv(1, 1, 2'b10, 0, 32'h21, 32'h55555555);
    chk("mis_sw21", {31'b0, misaligned}, 32'd1);
    chk("mis_rdata", rdata, 32'd0);
    edge1(); idle();
    chk("fault_set", {31'b0, fault}, 32'd1);
    chk("faddr_21", fault_addr, 32'h21);
    drv(1, 0, 2'b10, 0, 32'h20, 0); chk("sw21_blocked", rdata, 32'hAAAAAAAA);
    drv(1, 0, 2'b01, 0, 32'h33, 0); chk("mis_lh33", {31'b0, misaligned}, 32'd1);
    edge1(); idle();
    chk("faddr_kept", fault_addr, 32'h21);
    fault_clear = 1; edge1(); idle();
    chk("clr_fault", {31'b0, fault}, 32'd0);
    chk("clr_faddr", fault_addr, 32'd0);

    drv(1, 0, 2'b11, 0, 32'h40, 0); chk("mis_rsvd", {31'b0, misaligned}, 32'd1);
    edge1(); idle();
    chk("faddr_40", fault_addr, 32'h40);
    fault_clear = 1; drv(1, 0, 2'b10, 0, 32'h42, 0);
    edge1(); idle();
    chk("newwins_fault", {31'b0, fault}, 32'd1);
    chk("newwins_faddr", fault_addr, 32'h42);
    fault_clear = 1; edge1(); idle();
    drv(0, 0, 2'b11, 0, 32'h41, 0); chk("noacc_mis", {31'b0, misaligned}, 32'd0);

    // Read-before-write on a combined access.
    store(2'b10, 32'h50, 32'h22222222);
    drv(1, 1, 2'b10, 0, 32'h50, 32'h11111111); chk("rbw_old", rdata, 32'h22222222);
    edge1(); idle();
    drv(1, 0, 2'b10, 0, 32'h50, 0); chk("rbw_new", rdata, 32'h11111111);
    idle();

    // Asynchronous reset mid-store with a fault pending.
    drv(1, 0, 2'b01, 0, 32'h51, 0); edge1(); idle();
    chk("pre_rst_fault", {31'b0, fault}, 32'd1);
    drv(0, 1, 2'b10, 0, 32'h50, 32'h33333333);
    rst_n = 0; #1;
    chk("arst_fault", {31'b0, fault}, 32'd0);
    chk("arst_faddr", fault_addr, 32'd0);
    edge1(); idle();
    rst_n = 1;
    drv(1, 0, 2'b10, 0, 32'h50, 0); chk("rst_blocked", rdata, 32'h11111111);
    idle();

    store(2'b10, 32'h400, 32'hCAFEF00D);
    drv(1, 0, 2'b10, 0, 32'h000, 0); chk("wrap_0", rdata, 32'hCAFEF00D);
    drv(1, 0, 2'b00, 1, 32'h402, 0); chk("wrap_lbu", rdata, 32'h000000FE);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
